// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline sequencing controller for the 5-stage core.
// It handles load-use stalls, memory-busy freezes with a timeout error, and
// the front-end flush that follows a taken branch.
// Optional build macro HAZARD_STATS_EN adds three saturating event counters:
// stall_cycles, flush_events and busy_cycles.
//
// state  | meaning
// RUN    | normal issue
// LSTALL | one load-use bubble was just inserted; behaves like RUN
// MWAIT  | data memory was busy last cycle; a flush may be parked
// FLUSH  | IF/ID is still being flushed after a taken branch
module hazard_ctrl #(
  parameter int unsigned N           = 32,
  parameter int unsigned BR_PENALTY  = 2,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       idex_memread,
  input  logic [4:0] idex_rd,
  input  logic [4:0] ifid_rs1,
  input  logic [4:0] ifid_rs2,
  input  logic       ifid_use_rs2,
  input  logic       branch_taken,
  input  logic       mem_busy,
  output logic       pc_write,
  output logic       ifid_write,
  output logic       idex_write,
  output logic       exmem_write,
  output logic       idex_bubble,
  output logic       ifid_flush,
  output logic       pc_sel,
  output logic       mem_err,
  output logic [1:0] state
`ifdef HAZARD_STATS_EN
  ,
  output logic [15:0] stall_cycles,
  output logic [15:0] flush_events,
  output logic [15:0] busy_cycles
`endif
);

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_LSTALL = 2'd1,
    S_MWAIT  = 2'd2,
    S_FLUSH  = 2'd3
  } state_t;

  // Reject parameter values the counters cannot represent.
  if (N < 1 || BR_PENALTY < 1 || BR_PENALTY > 4 ||
      MEM_TIMEOUT < 1 || MEM_TIMEOUT > 255) begin : g_param_check
    $error("hazard_ctrl: parameter out of range");
  end

  state_t     r_state;
  logic       r_flush_pend;
  logic [2:0] r_flush_cnt;
  logic [7:0] r_busy_cnt;
  logic       r_mem_err;

  state_t     w_next_state;
  state_t     w_eff;
  logic       w_flush_pend_nxt;
  logic [2:0] w_flush_cnt_nxt;
  logic [7:0] w_busy_cnt_nxt;
  logic       w_load_use;
  logic       w_branch_acc;
  logic       w_flush_act;
  logic       w_stall;

  assign w_load_use = idex_memread && (idex_rd != 5'd0) &&
                      ((idex_rd == ifid_rs1) ||
                       (ifid_use_rs2 && (idex_rd == ifid_rs2)));

  // A cycle after a memory wait is judged as the state that was parked.
  assign w_eff = (r_state == S_MWAIT) ? (r_flush_pend ? S_FLUSH : S_RUN)
                                      : r_state;

  assign w_branch_acc = !mem_busy && branch_taken;
  assign w_flush_act  = !mem_busy && !branch_taken && (w_eff == S_FLUSH);
  assign w_stall      = !mem_busy && !branch_taken && (w_eff != S_FLUSH) &&
                        w_load_use;

  assign state   = r_state;
  assign mem_err = r_mem_err;

  // State, counters and the sticky timeout flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_RUN;
      r_flush_pend <= 1'b0;
      r_flush_cnt  <= 3'd0;
      r_busy_cnt   <= 8'd0;
      r_mem_err    <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_flush_pend <= w_flush_pend_nxt;
      r_flush_cnt  <= w_flush_cnt_nxt;
      r_busy_cnt   <= w_busy_cnt_nxt;
      if (mem_busy && (w_busy_cnt_nxt >= 8'(MEM_TIMEOUT))) begin
        r_mem_err <= 1'b1;
      end
    end
  end

  // Next-state and counter updates in mem_busy > branch > load-use order.
  always_comb begin
    w_next_state     = S_RUN;
    w_flush_pend_nxt = 1'b0;
    w_flush_cnt_nxt  = r_flush_cnt;
    w_busy_cnt_nxt   = 8'd0;
    if (mem_busy) begin
      w_next_state     = S_MWAIT;
      w_flush_pend_nxt = (w_eff == S_FLUSH);
      w_busy_cnt_nxt   = (r_busy_cnt == 8'hFF) ? r_busy_cnt
                                               : r_busy_cnt + 8'd1;
    end else if (w_branch_acc) begin
      w_flush_cnt_nxt = 3'(BR_PENALTY - 1);
      w_next_state    = (BR_PENALTY > 1) ? S_FLUSH : S_RUN;
    end else if (w_flush_act) begin
      w_flush_cnt_nxt = r_flush_cnt - 3'd1;
      w_next_state    = (r_flush_cnt == 3'd1) ? S_RUN : S_FLUSH;
    end else if (w_stall) begin
      w_next_state = S_LSTALL;
    end
  end

  // Mealy pipeline controls; reset forces free-running enables.
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_write  = 1'b1;
    exmem_write = 1'b1;
    idex_bubble = 1'b0;
    ifid_flush  = 1'b0;
    pc_sel      = 1'b0;
    if (rst_n) begin
      if (mem_busy) begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_write  = 1'b0;
        exmem_write = 1'b0;
      end
      if (w_branch_acc) begin
        pc_sel      = 1'b1;
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
      end
      if (w_flush_act) begin
        ifid_flush = 1'b1;
      end
      if (w_stall) begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_bubble = 1'b1;
      end
    end
  end

`ifdef HAZARD_STATS_EN
  logic [15:0] r_stall_cycles;
  logic [15:0] r_flush_events;
  logic [15:0] r_busy_cycles;

  // Saturating counters of stall cycles, accepted branches and busy cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cycles <= 16'd0;
      r_flush_events <= 16'd0;
      r_busy_cycles  <= 16'd0;
    end else begin
      if (w_stall && (r_stall_cycles != 16'hFFFF)) begin
        r_stall_cycles <= r_stall_cycles + 16'd1;
      end
      if (w_branch_acc && (r_flush_events != 16'hFFFF)) begin
        r_flush_events <= r_flush_events + 16'd1;
      end
      if (mem_busy && (r_busy_cycles != 16'hFFFF)) begin
        r_busy_cycles <= r_busy_cycles + 16'd1;
      end
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign flush_events = r_flush_events;
  assign busy_cycles  = r_busy_cycles;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus a random run
// against a cycle-level model of the pipeline controls.
module tb_hazard_ctrl;
  localparam int unsigned BRP = 2;
  localparam int unsigned TMO = 15;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       idex_memread = 1'b0;
  logic [4:0] idex_rd = 5'd0;
  logic [4:0] ifid_rs1 = 5'd0;
  logic [4:0] ifid_rs2 = 5'd0;
  logic       ifid_use_rs2 = 1'b0;
  logic       branch_taken = 1'b0;
  logic       mem_busy = 1'b0;
  wire        pc_write, ifid_write, idex_write, exmem_write;
  wire        idex_bubble, ifid_flush, pc_sel, mem_err;
  wire [1:0]  state;
`ifdef HAZARD_STATS_EN
  wire [15:0] stall_cycles, flush_events, busy_cycles;
`endif

  always #5 clk = ~clk;

  hazard_ctrl #(.N(32), .BR_PENALTY(BRP), .MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .idex_memread(idex_memread), .idex_rd(idex_rd),
    .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2), .ifid_use_rs2(ifid_use_rs2),
    .branch_taken(branch_taken), .mem_busy(mem_busy),
    .pc_write(pc_write), .ifid_write(ifid_write), .idex_write(idex_write),
    .exmem_write(exmem_write), .idex_bubble(idex_bubble),
    .ifid_flush(ifid_flush), .pc_sel(pc_sel), .mem_err(mem_err),
    .state(state)
`ifdef HAZARD_STATS_EN
    , .stall_cycles(stall_cycles), .flush_events(flush_events),
    .busy_cycles(busy_cycles)
`endif
  );

  // {pc_write, ifid_write, idex_write, exmem_write, idex_bubble, ifid_flush, pc_sel, mem_err}
  wire [7:0] outs = {pc_write, ifid_write, idex_write, exmem_write,
                     idex_bubble, ifid_flush, pc_sel, mem_err};

  int checks = 0;
  int fails  = 0;

  // Model: how many flush cycles are still owed, whether the last cycle was
  // a memory wait or a load-use stall, the busy run length and the error.
  int        m_flush_left, m_busy_run, m_stalls, m_flushes, m_busys;
  bit        m_wait, m_prev_stall, m_err;
  logic [7:0] exp_outs;
  logic [1:0] exp_state;

  function automatic bit lu_now();
    return idex_memread && (idex_rd != 5'd0) &&
           ((idex_rd == ifid_rs1) || (ifid_use_rs2 && (idex_rd == ifid_rs2)));
  endfunction

  function automatic int sat16(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  task automatic model_reset();
    m_flush_left = 0; m_busy_run = 0; m_stalls = 0; m_flushes = 0; m_busys = 0;
    m_wait = 0; m_prev_stall = 0; m_err = 0;
  endtask

  task automatic predict();
    bit lu;
    lu = lu_now();
    if (!rst_n)                exp_outs = 8'b1111_0000;
    else if (mem_busy)         exp_outs = {4'b0000, 3'b000, m_err};
    else if (branch_taken)     exp_outs = {4'b1111, 3'b111, m_err};
    else if (m_flush_left > 0) exp_outs = {4'b1111, 3'b010, m_err};
    else if (lu)               exp_outs = {4'b0011, 3'b100, m_err};
    else                       exp_outs = {4'b1111, 3'b000, m_err};
    if (!rst_n || (!m_wait && m_flush_left == 0 && !m_prev_stall)) exp_state = 2'd0;
    else if (m_wait)                exp_state = 2'd2;
    else if (m_flush_left > 0)      exp_state = 2'd3;
    else                            exp_state = 2'd1;
  endtask

  task automatic model_update();
    bit lu;
    lu = lu_now();
    if (mem_busy) begin
      m_busy_run = (m_busy_run < 255) ? m_busy_run + 1 : 255;
      if (m_busy_run >= TMO) m_err = 1;
      m_wait = 1; m_prev_stall = 0;
      m_busys = sat16(m_busys + 1);
    end else begin
      m_busy_run = 0; m_wait = 0;
      if (branch_taken) begin
        m_flush_left = BRP - 1; m_prev_stall = 0;
        m_flushes = sat16(m_flushes + 1);
      end else if (m_flush_left > 0) begin
        m_flush_left--; m_prev_stall = 0;
      end else begin
        m_prev_stall = lu;
        if (lu) m_stalls = sat16(m_stalls + 1);
      end
    end
  endtask

  task automatic drive(input logic mr, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic u2, input logic br,
                       input logic mb);
    idex_memread = mr; idex_rd = rd; ifid_rs1 = rs1; ifid_rs2 = rs2;
    ifid_use_rs2 = u2; branch_taken = br; mem_busy = mb;
    #1;
    predict();
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    model_update();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    for (int i = 0; i < 6; i++) begin
      drive(1'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), 1'($urandom));
      checks += 2;
      if (outs !== 8'b1111_0000) begin
        fails++; $display("FAIL reset_outs[%0d] got=%b want=%b", i, outs, 8'b1111_0000);
      end
      if (state !== 2'd0) begin
        fails++; $display("FAIL reset_state[%0d] got=%0d want=0", i, state);
      end
      #10;
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_load_use();
    logic [1:0] st [3] = '{2'd0, 2'd1, 2'd0};
    logic       pw [3] = '{1'b0, 1'b1, 1'b1};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      if (i == 0) drive(1, 5, 5, 9, 1, 0, 0);
      else        drive(0, 0, 5, 9, 1, 0, 0);
      checks += 3;
      if (outs !== exp_outs) begin
        fails++; $display("FAIL load_use_outs[%0d] got=%b want=%b", i, outs, exp_outs);
      end
      if (state !== st[i]) begin
        fails++; $display("FAIL load_use_state[%0d] got=%0d want=%0d", i, state, st[i]);
      end
      if (pc_write !== pw[i]) begin
        fails++; $display("FAIL load_use_pcw[%0d] got=%b want=%b", i, pc_write, pw[i]);
      end
      advance();
    end
  endtask

  task automatic test_rd_zero();
    do_reset();
    drive(1, 0, 0, 0, 1, 0, 0);
    checks += 2;
    if (outs !== 8'b1111_0000) begin
      fails++; $display("FAIL rd_zero_outs got=%b want=%b", outs, 8'b1111_0000);
    end
    advance();
    drive(0, 0, 0, 0, 0, 0, 0);
    if (state !== 2'd0) begin
      fails++; $display("FAIL rd_zero_state got=%0d want=0", state);
    end
    advance();
  endtask

  task automatic test_branch();
    logic [1:0] st [3] = '{2'd0, 2'd3, 2'd0};
    logic [7:0] ov [3] = '{8'b1111_1110, 8'b1111_0100, 8'b1111_0000};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      if (i == 0) drive(1, 4, 4, 0, 0, 1, 0);
      else        drive(0, 0, 0, 0, 0, 0, 0);
      checks += 3;
      if (outs !== exp_outs) begin
        fails++; $display("FAIL branch_outs[%0d] got=%b want=%b", i, outs, exp_outs);
      end
      if (outs !== ov[i]) begin
        fails++; $display("FAIL branch_direct[%0d] got=%b want=%b", i, outs, ov[i]);
      end
      if (state !== st[i]) begin
        fails++; $display("FAIL branch_state[%0d] got=%0d want=%0d", i, state, st[i]);
      end
      advance();
    end
  endtask

  task automatic test_busy_in_flush();
    logic [1:0] st [6] = '{2'd0, 2'd3, 2'd2, 2'd2, 2'd2, 2'd0};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      if (i == 0)      drive(0, 0, 0, 0, 0, 1, 0);
      else if (i <= 3) drive(0, 0, 0, 0, 0, 0, 1);
      else             drive(0, 0, 0, 0, 0, 0, 0);
      checks += 2;
      if (outs !== exp_outs) begin
        fails++; $display("FAIL busy_flush_outs[%0d] got=%b want=%b", i, outs, exp_outs);
      end
      if (state !== st[i]) begin
        fails++; $display("FAIL busy_flush_state[%0d] got=%0d want=%0d", i, state, st[i]);
      end
      advance();
    end
  endtask

  task automatic test_timeout();
    do_reset();
    for (int i = 1; i <= 16; i++) begin
      drive(0, 0, 0, 0, 0, 0, 1);
      checks++;
      if (outs !== exp_outs) begin
        fails++; $display("FAIL timeout_outs[%0d] got=%b want=%b", i, outs, exp_outs);
      end
      advance();
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (mem_err !== 1'b1) begin
      fails++; $display("FAIL timeout_sticky got=%b want=1", mem_err);
    end
    advance();
    drive(0, 0, 0, 0, 0, 0, 1);
    advance();
    drive(0, 0, 0, 0, 0, 0, 1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    checks += 3;
    if (mem_err !== 1'b0) begin
      fails++; $display("FAIL async_reset_err got=%b want=0", mem_err);
    end
    if (state !== 2'd0) begin
      fails++; $display("FAIL async_reset_state got=%0d want=0", state);
    end
    if (outs !== 8'b1111_0000) begin
      fails++; $display("FAIL async_reset_outs got=%b want=%b", outs, 8'b1111_0000);
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_back_to_back();
    logic [1:0] st [5] = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd0};
    logic       pw [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      case (i)
        0: drive(1, 1, 1, 0, 0, 0, 0);
        1: drive(0, 0, 1, 0, 0, 0, 0);
        2: drive(1, 2, 2, 0, 1, 0, 0);
        3: drive(0, 0, 2, 0, 1, 0, 0);
        default: drive(0, 3, 0, 0, 0, 0, 0);
      endcase
      checks += 3;
      if (outs !== exp_outs) begin
        fails++; $display("FAIL b2b_outs[%0d] got=%b want=%b", i, outs, exp_outs);
      end
      if (state !== st[i]) begin
        fails++; $display("FAIL b2b_state[%0d] got=%0d want=%0d", i, state, st[i]);
      end
      if (pc_write !== pw[i]) begin
        fails++; $display("FAIL b2b_pcw[%0d] got=%b want=%b", i, pc_write, pw[i]);
      end
      advance();
    end
`ifdef HAZARD_STATS_EN
    checks++;
    if (stall_cycles !== 16'd2) begin
      fails++; $display("FAIL b2b_stall_cycles got=%0d want=2", stall_cycles);
    end
`endif
  endtask

  task automatic test_random();
    int burst = 0;
    logic mb, br;
    for (int i = 0; i < 400; i++) begin
      if (burst == 0 && $urandom_range(0, 39) == 0) burst = $urandom_range(14, 18);
      if (burst > 0) begin mb = 1'b1; burst--; end
      else mb = ($urandom_range(0, 5) == 0);
      br = ($urandom_range(0, 7) == 0);
      drive(1'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 1'($urandom), br, mb);
      checks += 2;
      if (outs !== exp_outs) begin
        fails++; $display("FAIL random_outs[%0d] got=%b want=%b", i, outs, exp_outs);
      end
      if (state !== exp_state) begin
        fails++; $display("FAIL random_state[%0d] got=%0d want=%0d", i, state, exp_state);
      end
      advance();
    end
`ifdef HAZARD_STATS_EN
    checks += 3;
    if (stall_cycles !== 16'(m_stalls)) begin
      fails++; $display("FAIL stats_stall got=%0d want=%0d", stall_cycles, m_stalls);
    end
    if (flush_events !== 16'(m_flushes)) begin
      fails++; $display("FAIL stats_flush got=%0d want=%0d", flush_events, m_flushes);
    end
    if (busy_cycles !== 16'(m_busys)) begin
      fails++; $display("FAIL stats_busy got=%0d want=%0d", busy_cycles, m_busys);
    end
`endif
  endtask

  initial begin
    model_reset();
    test_reset();
    test_load_use();
    test_rd_zero();
    test_branch();
    test_busy_in_flush();
    test_timeout();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
